// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared state encoding and detector pattern for the sequence
//            detector and its serializer feeder.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int                 SEQ_LEN     = 5;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 5'b11010;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_reg
// Brief    : Loadable shift register presenting one bit of a word per shift.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_reg #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             cur_bit
);

  logic [WIDTH-1:0] sr;

  generate
    if (MSB_FIRST) begin : g_msb_first
      always_ff @(posedge clk) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
      end
      assign cur_bit = sr[WIDTH-1];
    end else begin : g_lsb_first
      always_ff @(posedge clk) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {1'b0, sr[WIDTH-1:1]};
      end
      assign cur_bit = sr[0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_serializer
// Brief    : Valid/ready word input, one bit per clock on bit_out with
//            zero-bubble streaming. Define PARITY_EN to append even parity.
// Revision : 1.0 - initial release
// ============================================================================
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic          cur_bit;
  logic          accept;
  logic          shift_en;
  logic          last_bit;
  logic          parity_bit;

`ifdef PARITY_EN
  assign last_bit = (state == S_PARITY);

  always_ff @(posedge clk) begin
    if (rst)         parity_bit <= 1'b0;
    else if (accept) parity_bit <= ^din;
  end
`else
  assign last_bit   = (state == S_SHIFT) && (count == '0);
  assign parity_bit = 1'b0;
`endif

  assign din_ready = !rst && ((state == S_IDLE) || last_bit);
  assign accept    = din_valid && din_ready;
  assign shift_en  = (state == S_SHIFT) && (count != '0);

  seq_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (shift_en),
    .din     (din),
    .cur_bit (cur_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      if (accept)        count <= LAST_CNT;
      else if (shift_en) count <= count - CW'(1);
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:   state_nx = accept ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (count != '0) state_nx = S_SHIFT;
`ifdef PARITY_EN
        else             state_nx = S_PARITY;
`else
        else             state_nx = accept ? S_SHIFT : S_IDLE;
`endif
      end
      S_PARITY: state_nx = accept ? S_SHIFT : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so the first bit shows one cycle after accept.
  always_comb begin
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    case (state)
      S_SHIFT: begin
        bit_out   = cur_bit;
        bit_valid = 1'b1;
      end
      S_PARITY: begin
        bit_out   = parity_bit;
        bit_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_bit_serializer
// Brief    : Self-checking bench for seq_bit_serializer, MSB- and LSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bit_serializer;
  import seq_det_pkg::*;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy_m, bit_m, val_m, busy_m;
  logic         rdy_l, bit_l, val_l, busy_l;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected remaining bit stream of each instance, head = bit on the wire now.
  logic qm[$];
  logic ql[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .bit_out(bit_m), .bit_valid(val_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .bit_out(bit_l), .bit_valid(val_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
`ifdef PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endtask

  // One clock: drive, check at negedge, then advance the model at posedge.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    logic exp_rdy;
    logic acc;
    rst       = r;
    din_valid = v;
    din       = d;
    @(negedge clk);
    exp_rdy = !r && (qm.size() <= 1);
    chk("ready_msb", rdy_m, exp_rdy);
    chk("ready_lsb", rdy_l, exp_rdy);
    chk("valid_msb", val_m, qm.size() > 0);
    chk("valid_lsb", val_l, ql.size() > 0);
    chk("busy_msb",  busy_m, qm.size() > 0);
    chk("busy_lsb",  busy_l, ql.size() > 0);
    chk("bit_msb",   bit_m, (qm.size() > 0) ? qm[0] : 1'b0);
    chk("bit_lsb",   bit_l, (ql.size() > 0) ? ql[0] : 1'b0);
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) push_word(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  // Holds valid with a stable word until the model says it was taken.
  task automatic send_word(input logic [W-1:0] w);
    logic taken;
    taken = 1'b0;
    for (int k = 0; k < 3 * W && !taken; k++) begin
      taken = (qm.size() <= 1);
      cycle(1'b0, 1'b1, w);
    end
    n_cmp++;
    if (!taken) begin
      n_err++;
      $error("FAIL accept_timeout cycle=%0d observed=0 expected=1", cyc);
    end
  endtask

  initial begin
    logic [W-1:0] pat;
    pat = SEQ_PATTERN;

    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 5'b10101);
    cycle(1'b1, 1'b0, '0);

    send_word(pat);
    idle(7);

    send_word(5'b11010);
    send_word(5'b10110);
    idle(12);

    send_word(5'b01011);
    idle(7);

    send_word(5'b11010);
    idle(2);
    cycle(1'b1, 1'b0, '0);
    idle(2);
    send_word(5'b11111);
    idle(7);

    send_word(5'b11010);
    cycle(1'b0, 1'b1, 5'b00111);
    cycle(1'b0, 1'b1, 5'b01100);
    cycle(1'b0, 1'b1, 5'b00001);
    idle(7);

    for (int it = 0; it < 80; it++) begin
      int gap;
      send_word(W'($urandom));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, W'($urandom));
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
